multi_door_alarm: RTL and testbench
===================================

MULTI_DOOR_ALARM -- requirements
Module: multi_door_alarm

Interface
REQ-001 Parameter N_DOORS, default 4: number of independent door channels (1..16).
REQ-002 Parameter DEBOUNCE_CYCLES, default 3: consecutive stable samples required before a sensor change is accepted (1..255).
REQ-003 Parameter ENTRY_DELAY, default 10: cycles a locked door may be open before its alarm fires (0..65535).
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 magnetic_sensor  input  N_DOORS  raw contact per door; 1 = door open, 0 = door closed.
REQ-007 locked  input  N_DOORS  per-door arm bit; 1 = armed.
REQ-008 alarm_ack  input  1  single-cycle pulse; clears latched alarms on closed doors.
REQ-009 alarm  output  N_DOORS  per-door alarm, registered.
REQ-010 pending  output  N_DOORS  per-door entry-delay-in-progress flag, registered.
REQ-011 any_alarm  output  1  registered OR of all alarm bits.
REQ-012 alarm_count  output  8  saturating count of alarm events (see Configuration).

Function
REQ-013 Each channel SHALL debounce its sensor: the debounced value SHALL take the raw value on the edge where the raw value has differed from the debounced value for DEBOUNCE_CYCLES consecutive sampled edges; any mismatch-free sample resets the stability count.
REQ-014 Each channel SHALL run a 3-state FSM: IDLE, PENDING, ALARM.
REQ-015 IDLE -> PENDING when debounced open = 1 and locked = 1; if ENTRY_DELAY = 0, IDLE -> ALARM directly.
REQ-016 PENDING SHALL load a delay counter with ENTRY_DELAY and decrement each cycle; ALARM SHALL be entered on the edge the counter reaches 0 (alarm high exactly ENTRY_DELAY cycles after pending first asserts).
REQ-017 PENDING -> IDLE when locked = 0 (disarm) or debounced open = 0 (door closed); disarm takes priority over expiry in the same cycle.
REQ-018 ALARM SHALL latch regardless of locked; ALARM -> IDLE only on alarm_ack = 1 while debounced open = 0.
REQ-019 alarm_ack while the door is still open SHALL be ignored for that channel.
REQ-020 alarm_ack in the same cycle as a channel's PENDING expiry SHALL NOT prevent that channel entering ALARM.
REQ-021 pending = 1 iff state is PENDING; alarm = 1 iff state is ALARM; outputs reflect state one edge after the transition condition is sampled.
REQ-022 Channels SHALL be fully independent; simultaneous events on several channels SHALL each be handled in the same cycle.

Reset
REQ-023 On rst_n = 0, all FSMs SHALL enter IDLE, debounced values SHALL be 0 (closed), counters SHALL be 0, and alarm, pending, any_alarm, alarm_count SHALL be 0 immediately.
REQ-024 Reset asserted mid-PENDING or mid-ALARM SHALL abort it with no alarm emitted after release until the full debounce and delay are re-satisfied.

Configuration
REQ-025 With macro DOOR_ALARM_COUNT_EN defined, alarm_count SHALL increment by the number of channels entering ALARM in that cycle, saturating at 255, cleared only by reset.
REQ-026 Without DOOR_ALARM_COUNT_EN, alarm_count SHALL be constant 0 and no counter logic SHALL be synthesised.

Structure
REQ-027 A shared package SHALL hold the FSM state enum (IDLE, PENDING, ALARM) and the alarm_count width constant (8).
REQ-028 Per-door debounce and FSM SHALL be a sub-module door_channel, instantiated N_DOORS times by generate; top level holds any_alarm and alarm_count.

Verification (N_DOORS=4, DEBOUNCE_CYCLES=3, ENTRY_DELAY=10)
REQ-029 locked=4'b0001, sensor[0] open for 2 cycles then closed -> no pending, no alarm (glitch rejected).
REQ-030 locked=4'b0001, sensor[0] held open -> pending[0] high 3 edges later, alarm[0] and any_alarm high 10 cycles after pending[0]; alarm_count=1 with macro, 0 without.
REQ-031 door 1 locked and opened, locked[1] dropped 5 cycles into PENDING -> pending[1] falls, alarm[1] never asserts.
REQ-032 alarm[2] latched, alarm_ack pulsed while open -> alarm[2] stays 1; close door, wait debounce, pulse ack -> alarm[2] = 0 next edge.
REQ-033 all 4 doors locked and opened together -> all alarm bits assert on the same edge, alarm_count = 4; rst_n pulsed low mid-ALARM -> all outputs 0 immediately.

Source files
------------

// File: rtl/multi_door_alarm_pkg.sv
// Shared definitions for the multi-door alarm block.
//   door_state_e : per-channel FSM state (IDLE, PENDING, ALARM)
//   COUNT_W      : width of the alarm_count output (8)
//   COUNT_MAX    : saturation value of alarm_count
//   sat_add      : saturating add used by the optional alarm event counter
// Optional feature macro: DOOR_ALARM_COUNT_EN (alarm event counter).
package multi_door_alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_ALARM   = 2'd2
    } door_state_e;

    localparam int COUNT_W = 8;
    localparam logic [COUNT_W-1:0] COUNT_MAX = 8'hFF;

    // Add up to 16 new events to the running count, clamping at COUNT_MAX.
    // The extra sum bit flags overflow because 255 + 16 fits in 9 bits.
    function automatic logic [COUNT_W-1:0] sat_add(input logic [COUNT_W-1:0] cur,
                                                   input logic [4:0]         inc);
        logic [COUNT_W:0] sum;
        sum = {1'b0, cur} + {4'b0000, inc};
        if (sum[COUNT_W]) begin
            return COUNT_MAX;
        end else begin
            return sum[COUNT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/door_channel.sv
// One door channel: sensor debouncer plus IDLE/PENDING/ALARM FSM.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   sensor      : raw contact (1 = open)
//   locked      : arm bit for this door
//   alarm_ack   : acknowledge pulse (clears alarm only while door closed)
//   alarm       : registered, 1 while in ALARM
//   pending     : registered, 1 while in PENDING
//   alarm_next  : value alarm will take on the next edge (lets the top
//                 register any_alarm and count entries on the same edge)
module door_channel
    import multi_door_alarm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int ENTRY_DELAY     = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sensor,
    input  logic locked,
    input  logic alarm_ack,
    output logic alarm,
    output logic pending,
    output logic alarm_next
);

    localparam logic [7:0]  DB_LIM   = 8'(DEBOUNCE_CYCLES);
    localparam logic [15:0] DLY_LOAD = 16'(ENTRY_DELAY);

    logic        deb_r;
    logic [7:0]  db_cnt_r;
    door_state_e state_r;
    door_state_e state_s;
    logic [15:0] dly_r;
    logic [15:0] dly_s;
    logic        alarm_r;
    logic        pending_r;
    logic        alarm_s;
    logic        pending_s;

    // Debouncer: adopt the raw value after DB_LIM consecutive mismatching samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_r    <= 1'b0;
            db_cnt_r <= 8'd0;
        end else if (sensor != deb_r) begin
            if ((db_cnt_r + 8'd1) >= DB_LIM) begin
                deb_r    <= sensor;
                db_cnt_r <= 8'd0;
            end else begin
                deb_r    <= deb_r;
                db_cnt_r <= db_cnt_r + 8'd1;
            end
        end else begin
            deb_r    <= deb_r;
            db_cnt_r <= 8'd0;
        end
    end

    // FSM state, delay counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            dly_r     <= 16'd0;
            alarm_r   <= 1'b0;
            pending_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            dly_r     <= dly_s;
            alarm_r   <= alarm_s;
            pending_r <= pending_s;
        end
    end

    // Next-state logic. In PENDING, dly_r holds the cycles still to wait;
    // reaching the last one moves to ALARM so alarm rises exactly
    // ENTRY_DELAY edges after pending. Disarm/close are checked before
    // expiry, and alarm_ack is not looked at in PENDING at all.
    always_comb begin
        state_s = state_r;
        dly_s   = dly_r;
        case (state_r)
            ST_IDLE: begin
                if (deb_r && locked) begin
                    if (DLY_LOAD == 16'd0) begin
                        state_s = ST_ALARM;
                    end else begin
                        state_s = ST_PENDING;
                        dly_s   = DLY_LOAD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PENDING: begin
                if (!locked || !deb_r) begin
                    state_s = ST_IDLE;
                    dly_s   = 16'd0;
                end else if (dly_r <= 16'd1) begin
                    state_s = ST_ALARM;
                    dly_s   = 16'd0;
                end else begin
                    dly_s   = dly_r - 16'd1;
                end
            end
            ST_ALARM: begin
                if (alarm_ack && !deb_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ALARM;
                end
            end
            default: begin
                state_s = ST_IDLE;
                dly_s   = 16'd0;
            end
        endcase
    end

    // Output decode from the next state; registered in the block above.
    always_comb begin
        alarm_s   = (state_s == ST_ALARM);
        pending_s = (state_s == ST_PENDING);
    end

    assign alarm      = alarm_r;
    assign pending    = pending_r;
    assign alarm_next = alarm_s;

endmodule

// File: rtl/multi_door_alarm.sv
// Multi-door alarm controller: N_DOORS independent door_channel instances
// plus the aggregate any_alarm flag and optional alarm event counter.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   magnetic_sensor  : raw door contacts (1 = open)
//   locked           : per-door arm bits
//   alarm_ack        : acknowledge pulse
//   alarm, pending   : per-door registered status
//   any_alarm        : registered OR of alarm bits
//   alarm_count      : saturating count of ALARM entries
// Macro DOOR_ALARM_COUNT_EN enables the counter; otherwise alarm_count is 0.
module multi_door_alarm
    import multi_door_alarm_pkg::*;
#(
    parameter int N_DOORS         = 4,
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int ENTRY_DELAY     = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_DOORS-1:0] magnetic_sensor,
    input  logic [N_DOORS-1:0] locked,
    input  logic               alarm_ack,
    output logic [N_DOORS-1:0] alarm,
    output logic [N_DOORS-1:0] pending,
    output logic               any_alarm,
    output logic [COUNT_W-1:0] alarm_count
);

    logic [N_DOORS-1:0] alarm_next_s;
    logic               any_alarm_r;

    for (genvar g = 0; g < N_DOORS; g++) begin : g_door
        door_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ENTRY_DELAY    (ENTRY_DELAY)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .sensor    (magnetic_sensor[g]),
            .locked    (locked[g]),
            .alarm_ack (alarm_ack),
            .alarm     (alarm[g]),
            .pending   (pending[g]),
            .alarm_next(alarm_next_s[g])
        );
    end

    // any_alarm is built from next-state alarm bits so it rises with them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_alarm_r <= 1'b0;
        end else begin
            any_alarm_r <= |alarm_next_s;
        end
    end

    assign any_alarm = any_alarm_r;

`ifdef DOOR_ALARM_COUNT_EN
    logic [N_DOORS-1:0] entering_s;
    logic [4:0]         inc_s;
    logic [COUNT_W-1:0] count_r;

    // Count channels moving into ALARM on the coming edge.
    always_comb begin
        entering_s = alarm_next_s & ~alarm;
        inc_s      = 5'd0;
        for (int i = 0; i < N_DOORS; i++) begin
            inc_s = inc_s + {4'b0000, entering_s[i]};
        end
    end

    // Saturating event counter, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 8'd0;
        end else begin
            count_r <= sat_add(count_r, inc_s);
        end
    end

    assign alarm_count = count_r;
`else
    assign alarm_count = 8'd0;
`endif

endmodule

// File: tb/tb_multi_door_alarm.sv
// Scoreboard bench for multi_door_alarm (N_DOORS=4, DEBOUNCE_CYCLES=3,
// ENTRY_DELAY=10). The driver applies stimulus, advances a timestamp-based
// reference model and queues the expected outputs; a negedge monitor pops
// and compares.
module tb_multi_door_alarm;

    localparam int ND = 4;
    localparam int DB = 3;
    localparam int ED = 10;

    logic          clk;
    logic          rst_n;
    logic [ND-1:0] magnetic_sensor;
    logic [ND-1:0] locked;
    logic          alarm_ack;
    logic [ND-1:0] alarm;
    logic [ND-1:0] pending;
    logic          any_alarm;
    logic [7:0]    alarm_count;

    multi_door_alarm #(
        .N_DOORS(ND), .DEBOUNCE_CYCLES(DB), .ENTRY_DELAY(ED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .magnetic_sensor(magnetic_sensor),
        .locked(locked), .alarm_ack(alarm_ack), .alarm(alarm),
        .pending(pending), .any_alarm(any_alarm), .alarm_count(alarm_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [ND-1:0] al;
        logic [ND-1:0] pe;
        logic          any;
        logic [7:0]    cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: door "mode" 0 idle, 1 waiting since pstart, 2 alarm.
    int   m_cyc;
    bit   m_deb[ND];
    int   m_run[ND];
    int   m_mode[ND];
    int   m_pstart[ND];
    int   m_cnt;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    task automatic model_reset();
        m_cyc = 0;
        m_cnt = 0;
        for (int d = 0; d < ND; d++) begin
            m_deb[d] = 1'b0; m_run[d] = 0; m_mode[d] = 0; m_pstart[d] = 0;
        end
    endtask

    function automatic exp_t model_outputs();
        exp_t e;
        e = '0;
        for (int d = 0; d < ND; d++) begin
            e.al[d] = (m_mode[d] == 2);
            e.pe[d] = (m_mode[d] == 1);
        end
        e.any = |e.al;
        e.cnt = 8'(m_cnt);
        return e;
    endfunction

    // Advance the model by one clock edge with the given inputs.
    task automatic model_edge(input logic [ND-1:0] s, input logic [ND-1:0] l, input logic a);
        int  enter;
        bit  old;
        enter = 0;
        m_cyc++;
        for (int d = 0; d < ND; d++) begin
            old = m_deb[d];
            case (m_mode[d])
                0: if (old && l[d]) begin
                       if (ED == 0) begin m_mode[d] = 2; enter++; end
                       else begin m_mode[d] = 1; m_pstart[d] = m_cyc; end
                   end
                1: if (!l[d] || !old) m_mode[d] = 0;
                   else if (m_cyc - m_pstart[d] >= ED) begin m_mode[d] = 2; enter++; end
                2: if (a && !old) m_mode[d] = 0;
                default: m_mode[d] = 0;
            endcase
            if (s[d] != old) begin
                m_run[d]++;
                if (m_run[d] >= DB) begin m_deb[d] = s[d]; m_run[d] = 0; end
            end else begin
                m_run[d] = 0;
            end
        end
`ifdef DOOR_ALARM_COUNT_EN
        m_cnt = (m_cnt + enter > 255) ? 255 : m_cnt + enter;
`endif
    endtask

    // One cycle of stimulus; expectation is queued once the edge has passed.
    task automatic step(input logic [ND-1:0] s, input logic [ND-1:0] l, input logic a);
        exp_t e;
        magnetic_sensor = s;
        locked          = l;
        alarm_ack       = a;
        model_edge(s, l, a);
        e = model_outputs();
        @(posedge clk);
        #1;
        exp_q.push_back(e);
    endtask

    task automatic steps(input int n, input logic [ND-1:0] s, input logic [ND-1:0] l);
        for (int i = 0; i < n; i++) step(s, l, 1'b0);
    endtask

    // Assert reset away from the clock edge and check outputs clear at once.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check({tag, "_alarm"},   int'(alarm), 0);
        check({tag, "_pending"}, int'(pending), 0);
        check({tag, "_any"},     int'(any_alarm), 0);
        check({tag, "_count"},   int'(alarm_count), 0);
        model_reset();
        magnetic_sensor = '0;
        locked          = '0;
        alarm_ack       = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compare DUT outputs against queued expectations.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("alarm",       int'(alarm),       int'(e.al));
            check("pending",     int'(pending),     int'(e.pe));
            check("any_alarm",   int'(any_alarm),   int'(e.any));
            check("alarm_count", int'(alarm_count), int'(e.cnt));
        end
    end

    initial begin
        logic [ND-1:0] rs;
        logic [ND-1:0] rl;
        rst_n           = 1'b0;
        magnetic_sensor = '0;
        locked          = '0;
        alarm_ack       = 1'b0;
        model_reset();
        #2;
        pulse_reset("reset");

        // Glitch shorter than the debounce window on door 0.
        steps(2, 4'b0001, 4'b0001);
        steps(6, 4'b0000, 4'b0001);
        // Door 0 held open: pending then alarm, then close and acknowledge.
        steps(18, 4'b0001, 4'b0001);
        steps(4, 4'b0000, 4'b0001);
        step(4'b0000, 4'b0001, 1'b1);
        steps(2, 4'b0000, 4'b0001);
        // Door 1 disarmed part way through the entry delay.
        steps(9, 4'b0010, 4'b0010);
        steps(15, 4'b0010, 4'b0000);
        steps(4, 4'b0000, 4'b0000);
        // Door 2: ack while open ignored, ack after close clears.
        steps(16, 4'b0100, 4'b0100);
        step(4'b0100, 4'b0100, 1'b1);
        steps(2, 4'b0100, 4'b0100);
        steps(4, 4'b0000, 4'b0100);
        step(4'b0000, 4'b0100, 1'b1);
        steps(2, 4'b0000, 4'b0100);
        // Door 3: ack coincides with entry-delay expiry.
        steps(13, 4'b1000, 4'b1000);
        step(4'b1000, 4'b1000, 1'b1);
        steps(3, 4'b1000, 4'b1000);
        steps(4, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 1'b1);
        steps(2, 4'b0000, 4'b0000);
        // All doors at once, then reset in the middle of ALARM.
        steps(16, 4'b1111, 4'b1111);
        pulse_reset("midreset");
        steps(6, 4'b1111, 4'b1111);
        pulse_reset("midpend");

        // Randomised traffic with slowly changing sensors and arm bits.
        rs = '0;
        rl = 4'b1111;
        for (int i = 0; i < 600; i++) begin
            for (int d = 0; d < ND; d++) begin
                if ($urandom_range(0, 11) == 0) rs[d] = ~rs[d];
                if ($urandom_range(0, 24) == 0) rl[d] = ~rl[d];
            end
            step(rs, rl, ($urandom_range(0, 7) == 0));
        end

        repeat (2) @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
